// File: rtl/instr_encoder_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : instr_encoder_tx
// Purpose  : Transmit side of the McCoy instruction path. Accepts an opcode
//            and operand over a valid/ready handshake, packs them into an
//            8-bit word {opcode[2:0], operand[4:0]} and serializes it MSB
//            first onto a framed bit-serial link. Opcode 3'b111 is rejected.
// Ports    : clk, rst_n             - clock, async active-low reset
//            in_valid/in_ready      - input handshake
//            in_opcode/in_operand   - instruction fields (sampled at accept)
//            abort                  - cancel the frame in flight
//            ser_data/ser_frame     - serial bit and frame envelope
//            ser_strobe             - first clock of each bit
//            tx_done, err_illegal   - single-cycle status pulses
//            frame_count            - completed frames, wraps at 256
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_tx #(
  parameter int BIT_CYCLES = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_opcode,
  input  logic [4:0] in_operand,
  input  logic       abort,
  output logic       ser_data,
  output logic       ser_frame,
  output logic       ser_strobe,
  output logic       tx_done,
  output logic       err_illegal,
  output logic [7:0] frame_count
);

  localparam logic [7:0] BIT_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam bit         GAP_NONE = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] bit_q;       // current bit index, 7 down to 0
  logic [7:0] cyc_q;       // clocks spent on the current bit
  logic [7:0] gap_q;       // clocks spent in GAP
  logic [7:0] shreg_q;     // remaining bits, next bit in [7]
  logic       ser_data_q;
  logic       ser_frame_q;
  logic       ser_strobe_q;
  logic       tx_done_q;
  logic       err_q;
  logic [7:0] count_q;

  logic [7:0] word_d;
  logic       illegal_d;

  // 'not' carries no operand, so the field is forced to zero.
  assign illegal_d = (in_opcode == 3'b111);
  assign word_d    = {in_opcode, (in_opcode == 3'b101) ? 5'b00000 : in_operand};

  assign in_ready    = (state_q == S_IDLE);
  assign ser_data    = ser_data_q;
  assign ser_frame   = ser_frame_q;
  assign ser_strobe  = ser_strobe_q;
  assign tx_done     = tx_done_q;
  assign err_illegal = err_q;
  assign frame_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_q        <= 3'd0;
      cyc_q        <= 8'd0;
      gap_q        <= 8'd0;
      shreg_q      <= 8'd0;
      ser_data_q   <= 1'b0;
      ser_frame_q  <= 1'b0;
      ser_strobe_q <= 1'b0;
      tx_done_q    <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      // Pulse outputs default low every cycle.
      ser_strobe_q <= 1'b0;
      tx_done_q    <= 1'b0;
      err_q        <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // abort blocks the accept entirely, including the error pulse.
          if (in_valid && !abort) begin
            if (illegal_d) begin
              err_q <= 1'b1;
            end else begin
              state_q      <= S_SHIFT;
              bit_q        <= 3'd7;
              cyc_q        <= 8'd0;
              ser_frame_q  <= 1'b1;
              ser_data_q   <= word_d[7];
              ser_strobe_q <= 1'b1;
              shreg_q      <= {word_d[6:0], 1'b0};
            end
          end
        end

        S_SHIFT: begin
          if (abort || ((cyc_q == BIT_LAST) && (bit_q == 3'd0))) begin
            // End of frame, normal or cancelled; only the normal end counts.
            state_q     <= GAP_NONE ? S_IDLE : S_GAP;
            gap_q       <= 8'd0;
            cyc_q       <= 8'd0;
            bit_q       <= 3'd0;
            shreg_q     <= 8'd0;
            ser_frame_q <= 1'b0;
            ser_data_q  <= 1'b0;
            if (!abort) begin
              tx_done_q <= 1'b1;
              count_q   <= count_q + 8'd1;
            end
          end else if (cyc_q == BIT_LAST) begin
            bit_q        <= bit_q - 3'd1;
            cyc_q        <= 8'd0;
            ser_data_q   <= shreg_q[7];
            ser_strobe_q <= 1'b1;
            shreg_q      <= {shreg_q[6:0], 1'b0};
          end else begin
            cyc_q <= cyc_q + 8'd1;
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_IDLE;
            gap_q   <= 8'd0;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          ser_frame_q <= 1'b0;
          ser_data_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instr_encoder_tx
// Purpose  : Self-checking bench for instr_encoder_tx. A frame-position model
//            predicts every output each cycle; directed sequences pin the
//            model with literal values, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_tx;

  localparam int BC  = 2;
  localparam int GAP = 1;
  localparam int FRAME_LEN = 8 * BC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_opcode = 3'd0;
  logic [4:0] in_operand = 5'd0;
  logic       abort = 1'b0;
  logic       in_ready, ser_data, ser_frame, ser_strobe, tx_done, err_illegal;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;

  instr_encoder_tx #(.BIT_CYCLES(BC), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_operand(in_operand), .abort(abort),
    .ser_data(ser_data), .ser_frame(ser_frame), .ser_strobe(ser_strobe),
    .tx_done(tx_done), .err_illegal(err_illegal), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // fpos: position within the frame (0..FRAME_LEN-1), -1 when no frame.
  // gleft: idle clocks still owed after a frame.
  int         fpos = -1;
  int         gleft = 0;
  logic [7:0] mword = 8'd0;
  logic [7:0] mcount = 8'd0;
  bit         mdone = 1'b0;
  bit         merr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpos = -1; gleft = 0; mword = 8'd0; mcount = 8'd0; mdone = 0; merr = 0;
    end else begin
      mdone = 0;
      merr  = 0;
      if (fpos >= 0) begin
        if (abort) begin
          fpos = -1; gleft = GAP;
        end else if (fpos == FRAME_LEN - 1) begin
          fpos = -1; gleft = GAP; mdone = 1; mcount = mcount + 8'd1;
        end else begin
          fpos++;
        end
      end else if (gleft > 0) begin
        gleft--;
      end else if (in_valid && !abort) begin
        if (in_opcode == 3'b111) merr = 1;
        else begin
          mword = {in_opcode, (in_opcode == 3'b101) ? 5'd0 : in_operand};
          fpos  = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",    in_ready,    (fpos < 0 && gleft == 0));
      chk("ser_frame",   ser_frame,   (fpos >= 0));
      chk("ser_data",    ser_data,    (fpos >= 0) ? mword[7 - fpos / BC] : 1'b0);
      chk("ser_strobe",  ser_strobe,  (fpos >= 0) && (fpos % BC == 0));
      chk("tx_done",     tx_done,     mdone);
      chk("err_illegal", err_illegal, merr);
      chk("frame_count", frame_count, mcount);
    end
    if (tx_done) done_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    errors++;
    $display("FAIL ready_timeout: in_ready never returned high");
  endtask

  // Returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [4:0] opnd);
    if (!in_ready) wait_ready();
    in_valid = 1'b1; in_opcode = op; in_operand = opnd;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic capture(output logic [7:0] w, output int strobes, output logic [63:0] raw);
    w = 8'd0; strobes = 0; raw = 64'd0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge clk);
      raw = {raw[62:0], ser_data};
      if (ser_strobe) begin
        w = {w[6:0], ser_data};
        strobes++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0]  w;
    logic [63:0] raw;
    int          nstb, d0, cyc, nstart;
    int          starts[3];
    logic        prev_frame;

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_count", frame_count, 8'd0);
    chk("rst_frame", ser_frame, 1'b0);
    rst_n = 1'b1;

    // li 001 / 01010 -> 8'h2A
    d0 = done_seen;
    send(3'b001, 5'b01010);
    capture(w, nstb, raw);
    chk("li_raw", raw[15:0], 16'b0000110011001100);
    chk("li_word", w, 8'h2A);
    chk("li_strobes", nstb, 8);
    @(negedge clk);
    chk("li_done", tx_done, 1'b1);
    chk("li_count", frame_count, 8'd1);
    wait_ready();
    chk("li_done_pulses", done_seen - d0, 1);

    // not 101 / 11111 -> operand forced to zero
    send(3'b101, 5'b11111);
    capture(w, nstb, raw);
    chk("not_word", w, 8'hA0);
    chk("not_strobes", nstb, 8);
    wait_ready();

    // illegal opcode
    send(3'b111, 5'b00011);
    @(negedge clk);
    chk("ill_err", err_illegal, 1'b1);
    chk("ill_frame", ser_frame, 1'b0);
    chk("ill_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("ill_err_pulse", err_illegal, 1'b0);
    chk("ill_count", frame_count, 8'd2);

    // back-to-back with in_valid held high
    in_valid = 1'b1; in_opcode = 3'b011; in_operand = 5'h05;
    nstart = 0; cyc = 0; prev_frame = 1'b0;
    while (nstart < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ser_frame && !prev_frame) begin
        starts[nstart] = cyc;
        nstart++;
        if (nstart == 3) in_valid = 1'b0;
      end
      prev_frame = ser_frame;
    end
    in_valid = 1'b0;
    chk("b2b_starts", nstart, 3);
    chk("b2b_space1", starts[1] - starts[0], 18);
    chk("b2b_space2", starts[2] - starts[1], 18);
    wait_ready();
    chk("b2b_count", frame_count, 8'd5);

    // abort on clock 5 of an sr frame
    d0 = done_seen;
    send(3'b110, 5'h15);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_frame", ser_frame, 1'b0);
    wait_ready();
    chk("abort_no_done", done_seen - d0, 0);
    chk("abort_count", frame_count, 8'd5);
    send(3'b001, 5'b01010);
    @(negedge clk);
    chk("post_abort_frame", ser_frame, 1'b1);
    wait_ready();
    chk("post_abort_count", frame_count, 8'd6);

    // reset mid-frame, then ja -> 8'h40
    send(3'b011, 5'h1F);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_frame", ser_frame, 1'b0);
    chk("mid_rst_data", ser_data, 1'b0);
    chk("mid_rst_count", frame_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(3'b010, 5'h00);
    capture(w, nstb, raw);
    chk("ja_word", w, 8'h40);
    wait_ready();
    chk("ja_count", frame_count, 8'd1);

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_opcode  = 3'($urandom_range(0, 7));
      in_operand = 5'($urandom);
      abort      = ($urandom_range(0, 19) == 0);
    end
    in_valid = 1'b0; abort = 1'b0;
    wait_ready();

    // 256 frames wrap the counter
    do_reset();
    d0 = done_seen;
    for (int i = 0; i < 255; i++) send(3'($urandom_range(0, 6)), 5'($urandom));
    wait_ready();
    chk("wrap_255", frame_count, 8'd255);
    send(3'b100, 5'h07);
    wait_ready();
    chk("wrap_0", frame_count, 8'd0);
    chk("wrap_done_pulses", done_seen - d0, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder_tx.md
Name: instr_encoder_tx

Overview:
- Transmit side of the McCoy instruction path. Accepts an opcode and operand from the program-load controller over a valid/ready handshake.
- Packs them into an 8-bit instruction word: opcode in [7:5], operand in [4:0].
- Rejects the undefined opcode 3'b111.
- Serializes each accepted word MSB-first onto a framed bit-serial link feeding program memory ahead of the opcode decoder.

Parameters:
BIT_CYCLES, 2, clocks each serial bit is held on ser_data; legal range 1..255
GAP_CYCLES, 1, idle clocks after each frame before in_ready reasserts; legal range 0..255

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  opcode/operand presented
in_ready  output  1  block can accept a word
in_opcode  input  3  opcode: bez 000, li 001, ja 010, add 011, lr 100, not 101, sr 110; 111 illegal
in_operand  input  5  immediate/register field
abort  input  1  synchronous cancel of the frame in flight
ser_data  output  1  serial instruction bit, MSB first
ser_frame  output  1  high for the whole 8-bit frame
ser_strobe  output  1  one-clock pulse on the first clock of each bit
tx_done  output  1  one-clock pulse when a frame completes normally
err_illegal  output  1  one-clock pulse when opcode 111 is offered and accepted
frame_count  output  8  count of completed frames; wraps 255 to 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - Outputs: in_ready=1 once rst_n is high; all other outputs 0; frame_count=0.
  - Bit, cycle and shift registers are cleared.
  - Assertion mid-frame drops ser_frame and ser_data immediately. The partial frame is discarded and not counted.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - Handshake completes on a rising edge where in_valid=1 and in_ready=1.
  - Opcode 111: word is not latched; err_illegal pulses on the next cycle; state stays IDLE; in_ready stays 1.
  - Legal opcode: latch word = {in_opcode, in_operand}. For not (101) the operand field is forced to 5'b00000. Go to SHIFT.
  - If abort=1 in the same cycle, abort wins: no accept, no error pulse.
- SHIFT:
  - in_ready=0 and ser_frame=1.
  - The bit index counts 7 down to 0; each bit is held BIT_CYCLES clocks.
  - ser_strobe=1 on the first clock of each bit, giving 8 pulses per frame.
  - Latency: accept at edge N puts bit7 on ser_data with ser_frame=1 and ser_strobe=1 during cycle N+1.
  - The frame lasts exactly 8*BIT_CYCLES clocks.
  - On the last clock of bit0, the next state is GAP, or IDLE if GAP_CYCLES=0.
  - On that transition: tx_done pulses one cycle, and frame_count increments modulo 256.
- GAP:
  - ser_frame=0, ser_data=0, in_ready=0 for GAP_CYCLES clocks, then IDLE.
- abort:
  - In SHIFT: the next cycle enters GAP (or IDLE if GAP_CYCLES=0) with ser_frame=0. No tx_done, no count increment.
  - In GAP or IDLE: no effect, except blocking the IDLE accept as above.
- ser_data=0 whenever ser_frame=0.
- in_operand and in_opcode are sampled only at the accept edge. Later changes do not affect the frame in flight.
- in_valid may stay high across frames. Back-to-back words are accepted on the first IDLE cycle after GAP. Minimum frame spacing is 8*BIT_CYCLES+GAP_CYCLES+1 clocks.
- Outputs are registered; there are no combinational paths from inputs to outputs except in_ready, which depends on state only.

Test Plan:
- Reset, then li opcode 001, operand 01010, BIT_CYCLES=2 -> word 8'h2A. ser_data over 16 clocks reads 0,0,0,0,1,1,0,0,1,1,0,0,1,1,0,0. ser_strobe gives 8 pulses. tx_done is one pulse. frame_count=1.
- not opcode 101, operand 11111 -> transmitted word 8'hA0 (operand zeroed). Bits 1,0,1,0,0,0,0,0.
- Offer opcode 111, operand 00011 -> err_illegal one pulse, ser_frame stays 0, in_ready stays 1, frame_count unchanged.
- Hold in_valid high with 3 words, BIT_CYCLES=1, GAP_CYCLES=1 -> frames start 10 clocks apart; frame_count=3.
- Assert abort on clock 5 of a sr frame (8'hC0) -> ser_frame falls the next cycle, no tx_done, frame_count unchanged, next word accepted after GAP.
- Drive rst_n low mid-frame and release -> all outputs 0 immediately, frame_count=0, then a clean ja frame (8'h40) transmits correctly.
- Send 256 frames -> frame_count wraps to 0 on the 256th tx_done.
